// File: rtl/register_rename_pkg.sv
// rtl/register_rename_pkg.sv - shared rename-stage sizes and register index types
//
// Purpose: architectural/physical register file sizes and the index typedefs
//          that are shared by rename, the issue queue and the ROB.
// Ports:   none (package).
// Config:  RENAME_BUSY_TABLE_EN (in register_rename.sv) is the optional ready table.

package register_rename_pkg;

  localparam int ARCH_REGS  = 32;
  localparam int PHYS_REGS  = 64;
  localparam int PREG_W     = 6;
  localparam int AREG_W     = 5;
  localparam int FREE_DEPTH = PHYS_REGS - ARCH_REGS;
  localparam int FL_PTR_W   = $clog2(FREE_DEPTH);
  localparam int FL_CNT_W   = FL_PTR_W + 1;

  typedef logic [AREG_W-1:0] arch_reg_t;
  typedef logic [PREG_W-1:0] phys_reg_t;

endpackage

// File: rtl/rename_free_list.sv
// rtl/rename_free_list.sv - circular FIFO of free physical registers
//
// Purpose: holds physical registers available for allocation. Resets holding
//          p32..p63 in order (full). Pops are ignored when empty and pushes
//          are dropped when full; a pop and a push in one cycle both happen.
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   pop_i            consume the head entry
//   push_i           append push_preg_i at the tail
//   push_preg_i      register being returned
//   head_preg_o      current head entry (valid when !empty_o)
//   count_o          number of entries, 0..FREE_DEPTH
//   empty_o, full_o  occupancy flags

module rename_free_list
  import register_rename_pkg::*;
(
  input  logic                clk,
  input  logic                rstn,
  input  logic                pop_i,
  input  logic                push_i,
  input  logic [PREG_W-1:0]   push_preg_i,
  output logic [PREG_W-1:0]   head_preg_o,
  output logic [FL_CNT_W-1:0] count_o,
  output logic                empty_o,
  output logic                full_o
);

  phys_reg_t             mem_q [FREE_DEPTH];
  logic [FL_PTR_W-1:0]   head_q, head_d;
  logic [FL_PTR_W-1:0]   tail_q, tail_d;
  logic [FL_CNT_W-1:0]   count_q, count_d;
  logic                  do_pop, do_push;

  assign empty_o     = (count_q == '0);
  assign full_o      = (count_q == FL_CNT_W'(FREE_DEPTH));
  assign head_preg_o = mem_q[head_q];
  assign count_o     = count_q;

  // Occupancy is judged on the pre-cycle count, so a push onto a full list
  // is dropped even when a pop frees a slot in the same cycle.
  assign do_pop  = pop_i  & ~empty_o;
  assign do_push = push_i & ~full_o;

  // Pointers are log2(FREE_DEPTH) wide and wrap naturally.
  always_comb begin
    head_d  = do_pop  ? head_q + 1'b1 : head_q;
    tail_d  = do_push ? tail_q + 1'b1 : tail_q;
    count_d = count_q + FL_CNT_W'(do_push) - FL_CNT_W'(do_pop);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FREE_DEPTH; i++) begin
        mem_q[i] <= PREG_W'(ARCH_REGS + i);
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= FL_CNT_W'(FREE_DEPTH);
    end else begin
      if (do_push) begin
        mem_q[tail_q] <= push_preg_i;
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/register_rename.sv
// rtl/register_rename.sv - RAT-based register rename stage, one instruction per cycle
//
// Purpose: maps rs1/rs2/rd to physical registers through the RAT, allocates a
//          new destination from the free list and reports the displaced
//          mapping for the ROB. Outputs are registered (1-cycle latency).
// Ports:
//   clk, rstn                         clock, asynchronous active-low reset
//   valid_in, rs1_in, rs2_in, rd_in,
//   rd_wen_in                         decoded instruction
//   stall_in                          issue-queue back-pressure (freezes outputs)
//   retire_valid_in, retire_preg_in   register returned to the free list
//   wb_valid_in, wb_preg_in           writeback (ready table only)
//   valid_out, srcReg1_p_out, srcReg2_p_out,
//   destReg_p_out, oldDestReg_p_out   renamed instruction
//   src1_ready_out, src2_ready_out    source availability (0 without ready table)
//   stall_out                         stall_in | free list empty
// Config: define RENAME_BUSY_TABLE_EN to build the physical-register ready table.

module register_rename
  import register_rename_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              valid_in,
  input  logic [AREG_W-1:0] rs1_in,
  input  logic [AREG_W-1:0] rs2_in,
  input  logic [AREG_W-1:0] rd_in,
  input  logic              rd_wen_in,
  input  logic              stall_in,
  input  logic              retire_valid_in,
  input  logic [PREG_W-1:0] retire_preg_in,
  input  logic              wb_valid_in,
  input  logic [PREG_W-1:0] wb_preg_in,
  output logic              valid_out,
  output logic [PREG_W-1:0] srcReg1_p_out,
  output logic [PREG_W-1:0] srcReg2_p_out,
  output logic [PREG_W-1:0] destReg_p_out,
  output logic [PREG_W-1:0] oldDestReg_p_out,
  output logic              src1_ready_out,
  output logic              src2_ready_out,
  output logic              stall_out
);

  phys_reg_t           rat_q [ARCH_REGS];
  phys_reg_t           free_head;
  logic [FL_CNT_W-1:0] free_count;
  logic                free_empty, free_full;

  logic                accept, alloc, retire_push;
  phys_reg_t           src1_p, src2_p, dest_p, old_p;

  logic                valid_q;
  phys_reg_t           src1_q, src2_q, dest_q, old_q;

  // A retire in the same cycle cannot lift an empty-list stall: the pushed
  // entry only becomes visible at the head on the next cycle.
  assign stall_out   = stall_in | free_empty;
  assign accept      = valid_in & ~stall_out;
  assign alloc       = accept & rd_wen_in & (rd_in != '0);
  assign retire_push = retire_valid_in & (retire_preg_in != '0);

  // Sources read the RAT before this instruction's own write, so rs == rd
  // yields the previous mapping. RAT[0] is never written, but x0 is forced
  // to p0 explicitly to keep that independent of RAT contents.
  assign src1_p = (rs1_in == '0) ? '0 : rat_q[rs1_in];
  assign src2_p = (rs2_in == '0) ? '0 : rat_q[rs2_in];
  assign dest_p = alloc ? free_head     : '0;
  assign old_p  = alloc ? rat_q[rd_in]  : '0;

  rename_free_list u_free_list (
    .clk         (clk),
    .rstn        (rstn),
    .pop_i       (alloc),
    .push_i      (retire_push),
    .push_preg_i (retire_preg_in),
    .head_preg_o (free_head),
    .count_o     (free_count),
    .empty_o     (free_empty),
    .full_o      (free_full)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        rat_q[i] <= PREG_W'(i);
      end
      valid_q <= 1'b0;
      src1_q  <= '0;
      src2_q  <= '0;
      dest_q  <= '0;
      old_q   <= '0;
    end else begin
      if (alloc) begin
        rat_q[rd_in] <= free_head;
      end
      // Back-pressure freezes every output register, valid included.
      if (!stall_in) begin
        valid_q <= accept;
        if (accept) begin
          src1_q <= src1_p;
          src2_q <= src2_p;
          dest_q <= dest_p;
          old_q  <= old_p;
        end
      end
    end
  end

  assign valid_out        = valid_q;
  assign srcReg1_p_out    = src1_q;
  assign srcReg2_p_out    = src2_q;
  assign destReg_p_out    = dest_q;
  assign oldDestReg_p_out = old_q;

`ifdef RENAME_BUSY_TABLE_EN
  logic [PHYS_REGS-1:0] ready_q, ready_d;
  logic                 src1_rdy, src2_rdy;
  logic                 src1_rdy_q, src2_rdy_q;

  // Allocation is applied after writeback so it wins on a collision.
  always_comb begin
    ready_d = ready_q;
    if (wb_valid_in) begin
      ready_d[wb_preg_in] = 1'b1;
    end
    if (alloc) begin
      ready_d[free_head] = 1'b0;
    end
    ready_d[0] = 1'b1;
  end

  // Same-cycle writeback bypass into the lookup.
  assign src1_rdy = (src1_p == '0) | ready_q[src1_p] | (wb_valid_in & (wb_preg_in == src1_p));
  assign src2_rdy = (src2_p == '0) | ready_q[src2_p] | (wb_valid_in & (wb_preg_in == src2_p));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ready_q    <= '1;
      src1_rdy_q <= 1'b0;
      src2_rdy_q <= 1'b0;
    end else begin
      ready_q <= ready_d;
      if (accept) begin
        src1_rdy_q <= src1_rdy;
        src2_rdy_q <= src2_rdy;
      end
    end
  end

  assign src1_ready_out = src1_rdy_q;
  assign src2_ready_out = src2_rdy_q;

  logic unused_fl;
  assign unused_fl = ^{free_count, free_full};
`else
  assign src1_ready_out = 1'b0;
  assign src2_ready_out = 1'b0;

  logic unused_fl;
  assign unused_fl = ^{free_count, free_full, wb_valid_in, wb_preg_in};
`endif

endmodule

// File: tb/tb_register_rename.sv
// tb/tb_register_rename.sv - randomized self-checking bench for register_rename

module tb_register_rename;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       valid_in = 1'b0;
  logic [4:0] rs1_in = '0, rs2_in = '0, rd_in = '0;
  logic       rd_wen_in = 1'b0, stall_in = 1'b0;
  logic       retire_valid_in = 1'b0;
  logic [5:0] retire_preg_in = '0;
  logic       wb_valid_in = 1'b0;
  logic [5:0] wb_preg_in = '0;
  logic       valid_out, src1_ready_out, src2_ready_out, stall_out;
  logic [5:0] srcReg1_p_out, srcReg2_p_out, destReg_p_out, oldDestReg_p_out;

  register_rename dut (
    .clk              (clk),
    .rstn             (rstn),
    .valid_in         (valid_in),
    .rs1_in           (rs1_in),
    .rs2_in           (rs2_in),
    .rd_in            (rd_in),
    .rd_wen_in        (rd_wen_in),
    .stall_in         (stall_in),
    .retire_valid_in  (retire_valid_in),
    .retire_preg_in   (retire_preg_in),
    .wb_valid_in      (wb_valid_in),
    .wb_preg_in       (wb_preg_in),
    .valid_out        (valid_out),
    .srcReg1_p_out    (srcReg1_p_out),
    .srcReg2_p_out    (srcReg2_p_out),
    .destReg_p_out    (destReg_p_out),
    .oldDestReg_p_out (oldDestReg_p_out),
    .src1_ready_out   (src1_ready_out),
    .src2_ready_out   (src2_ready_out),
    .stall_out        (stall_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: RAT as an int array, free list as a queue.
  int m_rat [32];
  int m_fl [$];
  bit m_ready [64];
  int e_valid, e_s1, e_s2, e_d, e_o, e_r1, e_r2;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rat[i] = i;
    m_fl.delete();
    for (int i = 0; i < 32; i++) m_fl.push_back(32 + i);
    for (int i = 0; i < 64; i++) m_ready[i] = 1'b1;
    e_valid = 0; e_s1 = 0; e_s2 = 0; e_d = 0; e_o = 0; e_r1 = 0; e_r2 = 0;
  endtask

  function automatic int src_ready(int p, bit wv, int wp);
`ifdef RENAME_BUSY_TABLE_EN
    return (p == 0 || m_ready[p] || (wv && wp == p)) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  task automatic check_outputs(input string pfx);
    check({pfx, "_valid"}, valid_out, e_valid);
    check({pfx, "_src1"}, srcReg1_p_out, e_s1);
    check({pfx, "_src2"}, srcReg2_p_out, e_s2);
    check({pfx, "_dest"}, destReg_p_out, e_d);
    check({pfx, "_old"}, oldDestReg_p_out, e_o);
    check({pfx, "_rdy1"}, src1_ready_out, e_r1);
    check({pfx, "_rdy2"}, src2_ready_out, e_r2);
  endtask

  // Called just after a falling edge; returns just after the next one.
  task automatic step(input bit v, input int r1, input int r2, input int rd, input bit wen,
                      input bit st, input bit rv, input int rp, input bit wv, input int wp);
    bit exp_stall, push_ok, alloc;
    int alloc_p;
    valid_in = v; rs1_in = 5'(r1); rs2_in = 5'(r2); rd_in = 5'(rd); rd_wen_in = wen;
    stall_in = st; retire_valid_in = rv; retire_preg_in = 6'(rp);
    wb_valid_in = wv; wb_preg_in = 6'(wp);
    #1;
    exp_stall = st || (m_fl.size() == 0);
    check("stall_out", stall_out, exp_stall);
    push_ok = rv && rp != 0 && m_fl.size() < 32;
    alloc = 0; alloc_p = 0;
    if (!st) begin
      if (v && !exp_stall) begin
        e_valid = 1;
        e_s1 = (r1 == 0) ? 0 : m_rat[r1];
        e_s2 = (r2 == 0) ? 0 : m_rat[r2];
        e_r1 = src_ready(e_s1, wv, wp);
        e_r2 = src_ready(e_s2, wv, wp);
        if (wen && rd != 0) begin
          alloc = 1;
          alloc_p = m_fl.pop_front();
          e_d = alloc_p;
          e_o = m_rat[rd];
          m_rat[rd] = alloc_p;
        end else begin
          e_d = 0;
          e_o = 0;
        end
      end else begin
        e_valid = 0;
      end
    end
    if (wv) m_ready[wp] = 1'b1;
    if (alloc) m_ready[alloc_p] = 1'b0;
    if (push_ok) m_fl.push_back(rp);
    @(negedge clk);
    check_outputs("out");
  endtask

  initial begin
    int p;
    model_reset();
    @(negedge clk);
    check_outputs("reset");
    check("reset_stall", stall_out, 0);
    rstn = 1'b1;

    // Basic renames.
    step(1, 1, 2, 3, 1, 0, 0, 0, 0, 0);
    check("t1_src1", srcReg1_p_out, 1);
    check("t1_dest", destReg_p_out, 32);
    check("t1_old", oldDestReg_p_out, 3);
    step(1, 3, 0, 3, 1, 0, 0, 0, 0, 0);
    check("t2_src1", srcReg1_p_out, 32);
    check("t2_dest", destReg_p_out, 33);
    check("t2_old", oldDestReg_p_out, 32);
    step(1, 1, 2, 0, 1, 0, 0, 0, 0, 0);
    check("t3_dest", destReg_p_out, 0);
    check("t3_old", oldDestReg_p_out, 0);

    // Drain the free list.
    for (int i = 0; i < 40 && m_fl.size() > 0; i++)
      step(1, $urandom_range(31), $urandom_range(31), 1 + i % 31, 1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 6, 1, 0, 0, 0, 0, 0);
    check("empty_stall", stall_out, 1);
    check("empty_valid", valid_out, 0);
    // Retire into an empty list: still stalled this cycle.
    step(1, 1, 1, 6, 1, 0, 1, 5, 0, 0);
    check("empty_retire_valid", valid_out, 0);
    step(1, 1, 1, 6, 1, 0, 0, 0, 0, 0);
    check("wrap_dest", destReg_p_out, 5);

    // Back-pressure hold then release.
    step(0, 0, 0, 0, 0, 0, 1, 20, 0, 0);
    step(1, 6, 6, 7, 1, 1, 0, 0, 0, 0);
    step(1, 6, 6, 7, 1, 1, 0, 0, 0, 0);
    step(1, 6, 6, 7, 1, 1, 0, 0, 0, 0);
    check("hold_dest", destReg_p_out, 5);
    step(1, 6, 6, 7, 1, 0, 0, 0, 0, 0);
    check("release_dest", destReg_p_out, 20);
    check("release_src1", srcReg1_p_out, 5);

    // Count 10, simultaneous alloc and retire of p7, retire of p0 ignored.
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0, 1, 40 + i, 0, 0);
    step(1, 0, 0, 9, 1, 0, 1, 7, 0, 0);
    check("same_cycle_dest", destReg_p_out, 40);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 11; i++) step(1, 0, 0, 10, 1, 0, 0, 0, 0, 0);
    check("after_drain_stall", stall_out, 1);
    check("last_pop_is_p7", oldDestReg_p_out, 49);

    // Asynchronous reset mid-operation.
    step(0, 0, 0, 0, 0, 0, 1, 33, 0, 0);
    valid_in = 1; rd_in = 5; rd_wen_in = 1; stall_in = 0;
    #2 rstn = 1'b0;
    #1;
    model_reset();
    check_outputs("midreset");
    @(negedge clk);
    rstn = 1'b1;

    // Ready table.
    step(1, 0, 0, 4, 1, 0, 0, 0, 0, 0);
    p = e_d;
    check("busy_alloc", destReg_p_out, 32);
    step(1, 4, 0, 8, 0, 0, 0, 0, 0, 0);
    check("busy_consumer_rdy", src1_ready_out, 0);
    step(1, 4, 0, 8, 0, 0, 0, 0, 1, p);
`ifdef RENAME_BUSY_TABLE_EN
    check("busy_wb_bypass_rdy", src1_ready_out, 1);
`else
    check("busy_disabled_rdy", src1_ready_out, 0);
`endif

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(9) < 8), $urandom_range(31), $urandom_range(31),
           $urandom_range(31), ($urandom_range(9) < 8), ($urandom_range(9) < 2),
           ($urandom_range(1) == 1), $urandom_range(63),
           ($urandom_range(9) < 3), $urandom_range(63));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
